// File: rtl/llc_cmd_issuer_pkg.sv
// Shared LLC command definitions: code/address widths, command enum, and the
// legality check used by the trace-side issuer.
package llc_cmd_issuer_pkg;

  localparam int CMDSIZE   = 4;
  localparam int ADDR_BITS = 32;

  typedef enum logic [CMDSIZE-1:0] {
    CMD_L1_RD    = 4'h0,
    CMD_L1_WR    = 4'h1,
    CMD_L1_IRD   = 4'h2,
    CMD_SNP_INV  = 4'h3,
    CMD_SNP_RD   = 4'h4,
    CMD_SNP_WR   = 4'h5,
    CMD_SNP_RWIM = 4'h6,
    CMD_CLEAR    = 4'h8,
    CMD_PRINT    = 4'h9,
    CMD_NOP      = 4'hF
  } cmd_t;

  typedef struct packed {
    logic [CMDSIZE-1:0]   cmd;
    logic [ADDR_BITS-1:0] addr;
  } rec_t;

  function automatic logic is_legal_cmd(input logic [CMDSIZE-1:0] c);
    case (c)
      CMD_L1_RD, CMD_L1_WR, CMD_L1_IRD, CMD_SNP_INV, CMD_SNP_RD,
      CMD_SNP_WR, CMD_SNP_RWIM, CMD_CLEAR, CMD_PRINT: is_legal_cmd = 1'b1;
      default:                                         is_legal_cmd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/llc_cmd_fifo.sv
// Small power-of-two FIFO; an extra pointer bit separates full from empty.
module llc_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/llc_cmd_issuer.sv
// Trace-to-LLC command sequencer: buffers legal records, issues one at a time
// with ack, inserts a NOP gap between records, and watches for a stalled LLC.
module llc_cmd_issuer
  import llc_cmd_issuer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CMDSIZE-1:0]   in_cmd,
  input  logic [ADDR_BITS-1:0] in_addr,
  output logic                 llc_valid,
  output logic [CMDSIZE-1:0]   llc_cmd,
  output logic [ADDR_BITS-1:0] llc_addr,
  input  logic                 llc_ack,
  output logic [31:0]          issued_count,
  output logic [15:0]          dropped_count,
  output logic                 err_timeout,
  output logic                 idle
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;

  state_t          state;
  logic [WD_W-1:0] wd_cnt;
  logic            full, empty, in_legal, push, pop;
  rec_t            head, in_rec;

  assign in_rec   = '{cmd: in_cmd, addr: in_addr};
  assign in_legal = is_legal_cmd(in_cmd);
  assign in_ready = !full;
  assign push     = in_valid && in_ready && in_legal;
  assign pop      = (state == ST_ISSUE) && llc_ack;
  assign idle     = empty && (state == ST_IDLE);

  llc_cmd_fifo #(.DEPTH(DEPTH), .W($bits(rec_t))) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (in_rec),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      llc_valid     <= 1'b0;
      llc_cmd       <= CMD_NOP;
      llc_addr      <= '0;
      issued_count  <= '0;
      dropped_count <= '0;
      err_timeout   <= 1'b0;
      wd_cnt        <= '0;
    end else begin
      if (in_valid && in_ready && !in_legal && dropped_count != 16'hFFFF)
        dropped_count <= dropped_count + 16'd1;
      case (state)
        ST_IDLE: begin
          // An empty FIFO in IDLE forwards the record being pushed, so it
          // reaches the LLC the cycle after it is accepted.
          if (!empty) begin
            state     <= ST_ISSUE;
            llc_valid <= 1'b1;
            llc_cmd   <= head.cmd;
            llc_addr  <= head.addr;
            wd_cnt    <= '0;
          end else if (push) begin
            state     <= ST_ISSUE;
            llc_valid <= 1'b1;
            llc_cmd   <= in_cmd;
            llc_addr  <= in_addr;
            wd_cnt    <= '0;
          end
        end
        ST_ISSUE: begin
          if (llc_ack) begin
            state        <= ST_GAP;
            llc_valid    <= 1'b0;
            llc_cmd      <= CMD_NOP;
            llc_addr     <= '0;
            issued_count <= issued_count + 32'd1;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        ST_GAP: begin
          if (!empty) begin
            state     <= ST_ISSUE;
            llc_valid <= 1'b1;
            llc_cmd   <= head.cmd;
            llc_addr  <= head.addr;
            wd_cnt    <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_llc_cmd_issuer.sv
// Scoreboard bench for llc_cmd_issuer: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the issuer.
module tb_llc_cmd_issuer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [3:0]  in_cmd;
  logic [31:0] in_addr;
  logic        llc_valid, llc_ack;
  logic [3:0]  llc_cmd;
  logic [31:0] llc_addr;
  logic [31:0] issued_count;
  logic [15:0] dropped_count;
  logic        err_timeout, idle;

  llc_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
    .llc_valid(llc_valid), .llc_cmd(llc_cmd), .llc_addr(llc_addr), .llc_ack(llc_ack),
    .issued_count(issued_count), .dropped_count(dropped_count),
    .err_timeout(err_timeout), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ack_mode = 0;   // 0 hold low, 1 always ack, 2 random ack
  int issue_events = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [3:0] c);
    return (c <= 4'd6) || (c == 4'd8) || (c == 4'd9);
  endfunction

  always @(negedge clk)
    llc_ack = (ack_mode == 1) || (ack_mode == 2 && $urandom_range(0, 2) == 0);

  // Reference model: records accepted but not yet acknowledged, in order.
  logic [35:0] exp_q [$];
  int          iss_m = 0, stall = 0, wait_cnt = 0;
  int          drop_m = 0;
  bit          err_m = 0, prev_valid = 0, gap_now = 0;

  initial begin
    bit s_rst, s_acc, s_pop, s_stall;
    logic [3:0]  s_cmd;
    logic [31:0] s_addr;
    forever begin
      @(negedge clk); #4;
      s_rst   = reset;
      s_acc   = in_valid && in_ready;
      s_cmd   = in_cmd;
      s_addr  = in_addr;
      s_pop   = llc_valid && llc_ack;
      s_stall = llc_valid && !llc_ack;
      @(posedge clk); #1;
      gap_now = 0;
      if (s_rst) begin
        exp_q.delete();
        iss_m = 0; drop_m = 0; err_m = 0; stall = 0;
      end else begin
        if (s_pop) begin
          gap_now = 1;
          if (exp_q.size() == 0) chk("pop_without_record", 1, 0);
          else void'(exp_q.pop_front());
          iss_m++;
        end
        if (s_acc) begin
          if (legal(s_cmd)) exp_q.push_back({s_cmd, s_addr});
          else if (drop_m < 65535) drop_m++;
        end
        if (s_stall) begin
          stall++;
          if (stall >= TIMEOUT) err_m = 1;
        end else stall = 0;
      end
      chk("in_ready", in_ready, exp_q.size() < DEPTH);
      chk("issued_count", issued_count, iss_m);
      chk("dropped_count", dropped_count, drop_m);
      chk("err_timeout", err_timeout, err_m);
      chk("idle", idle, exp_q.size() == 0 && !gap_now);
      if (gap_now) chk("gap_valid", llc_valid, 0);
      if (llc_valid) begin
        if (!prev_valid) begin
          issue_events++;
          if (exp_q.size() == 0) chk("issue_unexpected", 1, 0);
          else chk("issue_record", {llc_cmd, llc_addr}, exp_q[0]);
        end
      end else begin
        chk("nop_cmd", llc_cmd, 4'hF);
        chk("nop_addr", llc_addr, 0);
      end
      if (exp_q.size() > 0 && !llc_valid) begin
        wait_cnt++;
        if (wait_cnt > 2) chk("issue_stuck", wait_cnt, 2);
      end else wait_cnt = 0;
      prev_valid = llc_valid;
    end
  end

  task automatic send(input logic [3:0] c, input logic [31:0] a);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_cmd = c; in_addr = a;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("send_timeout", 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int ev0;
    reset = 1'b1; in_valid = 1'b0; in_cmd = '0; in_addr = '0; llc_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_llc_valid", llc_valid, 0);
    chk("rst_llc_cmd", llc_cmd, 4'hF);
    chk("rst_idle", idle, 1);

    // single record, one-cycle latency, ack, then gap
    ack_mode = 1;
    send(4'h0, 32'h1000);
    chk("t1_valid", llc_valid, 1);
    chk("t1_cmd", llc_cmd, 4'h0);
    chk("t1_addr", llc_addr, 32'h1000);
    @(negedge clk);
    chk("t1_gap_cmd", llc_cmd, 4'hF);
    chk("t1_issued", issued_count, 1);
    @(negedge clk);
    chk("t1_idle", idle, 1);

    // two identical records separated by a NOP
    ev0 = issue_events;
    send(4'h1, 32'h2040);
    send(4'h1, 32'h2040);
    repeat (4) @(negedge clk);
    chk("t2_issued", issued_count, 3);
    chk("t2_events", issue_events - ev0, 2);

    // back-pressure: FIFO fills behind a stalled LLC
    ack_mode = 0;
    for (int k = 0; k < 4; k++) send(4'(k), 32'h3000 + 32'(k * 4));
    chk("t3_full", in_ready, 0);
    fork send(4'h5, 32'h3010); join_none
    repeat (3) @(negedge clk);
    chk("t3_held", in_ready, 0);
    chk("t3_no_issue", issued_count, 3);
    ack_mode = 1;
    wait fork;
    repeat (12) @(negedge clk);
    chk("t3_issued", issued_count, 8);
    chk("t3_idle", idle, 1);

    // illegal codes are consumed and counted
    send(4'h7, 32'h7000);
    send(4'h9, 32'h9000);
    send(4'hA, 32'hA000);
    send(4'hF, 32'hF000);
    repeat (4) @(negedge clk);
    chk("t4_dropped", dropped_count, 3);
    chk("t4_issued", issued_count, 9);

    // watchdog
    ack_mode = 0;
    send(4'h2, 32'h5000);
    repeat (20) @(negedge clk);
    chk("t5_err_early", err_timeout, 0);
    repeat (50) @(negedge clk);
    chk("t5_err_set", err_timeout, 1);
    ack_mode = 1;
    repeat (4) @(negedge clk);
    chk("t5_issued", issued_count, 10);
    chk("t5_err_sticky", err_timeout, 1);

    // reset while issuing with records queued
    ack_mode = 0;
    send(4'h4, 32'h6000);
    send(4'h5, 32'h6004);
    send(4'h6, 32'h6008);
    chk("t6_busy", llc_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_valid", llc_valid, 0);
    chk("t6_cmd", llc_cmd, 4'hF);
    chk("t6_idle", idle, 1);
    chk("t6_issued", issued_count, 0);
    chk("t6_dropped", dropped_count, 0);
    chk("t6_err", err_timeout, 0);
    ack_mode = 1;
    repeat (10) @(negedge clk);
    chk("t6_no_stale", llc_valid, 0);

    // random traffic against the model
    ack_mode = 2;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(4'($urandom_range(0, 15)), $urandom);
    end
    ack_mode = 1;
    repeat (40) @(negedge clk);
    chk("rand_drained_idle", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

endmodule
